// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard and a
// hardware clear sequencer that zeroes the array after reset or on request.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   rd_addr/rd_data NRD combinational read ports (x0 reads 0)
//   rd_pending      per read port: register has an outstanding write
//   wr_en/addr/data NWR write ports; highest-index port wins on conflict
//   sb_set_en/addr  mark a destination register pending at issue
//   clear_req       one-cycle pulse requesting a full clear
//   busy            clear sequence active; writes and sets ignored
//
// Build option: REGFILE_WR_BYPASS_EN forwards same-cycle write data
// to matching reads while idle.

module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NRD*$clog2(NREGS)-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0]            rd_data,
  output logic [NRD-1:0]                 rd_pending,
  input  logic [NWR-1:0]                 wr_en,
  input  logic [NWR*$clog2(NREGS)-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0]            wr_data,
  input  logic                           sb_set_en,
  input  logic [$clog2(NREGS)-1:0]       sb_set_addr,
  input  logic                           clear_req,
  output logic                           busy
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [XLEN-1:0]   mem [NREGS];

  logic [AW-1:0]     ra;
  logic [NRD*XLEN-1:0] rd_data_c;
  logic [NRD-1:0]    rd_pend_c;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == LAST) state_d = IDLE;
      end
      IDLE: begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j]) pend_d[wr_addr[j*AW +: AW]] = 1'b0;
        end
        // a set lands after the clears so it wins on the same address
        if (sb_set_en && sb_set_addr != '0)
          pend_d[sb_set_addr] = 1'b1;
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = AW'(1);
          pend_d  = '0;
        end
      end
      default: ;
    endcase
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= AW'(1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  // Array has no reset; the clear walk zeroes it. Later ports
  // overwrite earlier ones through NBA ordering.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[ptr_q] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_pend_c = '0;
    ra        = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (state_q == IDLE && ra != '0) begin
        rd_data_c[i*XLEN +: XLEN] = mem[ra];
        rd_pend_c[i]              = pend_q[ra];
`ifdef REGFILE_WR_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
            rd_data_c[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
            rd_pend_c[i] = sb_set_en && (sb_set_addr == ra);
          end
        end
`endif
      end
    end
  end

  assign rd_data    = rd_data_c;
  assign rd_pending = rd_pend_c;
  assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random
// traffic compared each cycle against a behavioural model.

module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_pending;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 sb_set_en;
  logic [AW-1:0]        sb_set_addr;
  logic                 clear_req;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int bl;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pending(rd_pending),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: register values, pending flags and the
  // number of cycles the clear still keeps the file unavailable.
  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_pend [NREGS];
  int              m_busy = 0;

  always @(negedge clk) begin : cmp
    logic [XLEN-1:0] ed;
    logic            ep;
    logic [AW-1:0]   a;
    if (reset) begin
      m_busy = NREGS - 1;
      for (int r = 0; r < NREGS; r++) begin
        m_mem[r]  = '0;
        m_pend[r] = 1'b0;
      end
    end
    chk("busy", 32'(busy), 32'(m_busy > 0));
    for (int i = 0; i < NRD; i++) begin
      a  = rd_addr[i*AW +: AW];
      ed = '0;
      ep = 1'b0;
      if (m_busy == 0 && a != '0) begin
        ed = m_mem[a];
        ep = m_pend[a];
`ifdef REGFILE_WR_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
            ed = wr_data[j*XLEN +: XLEN];
            ep = sb_set_en && (sb_set_addr == a);
          end
        end
`endif
      end
      chk($sformatf("rd_data%0d", i),
          rd_data[i*XLEN +: XLEN], ed);
      chk($sformatf("rd_pending%0d", i),
          32'(rd_pending[i]), 32'(ep));
    end
    if (!reset) begin
      if (m_busy > 0) begin
        m_busy--;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j]) begin
            a = wr_addr[j*AW +: AW];
            if (a != '0) m_mem[a] = wr_data[j*XLEN +: XLEN];
            m_pend[a] = 1'b0;
          end
        end
        if (sb_set_en && sb_set_addr != '0)
          m_pend[sb_set_addr] = 1'b1;
        if (clear_req) begin
          m_busy = NREGS - 1;
          for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    wr_en     = '0;
    sb_set_en = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a,
                    input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic rnd_in(input int amax);
    for (int j = 0; j < NWR; j++) begin
      wr_en[j] = 1'($urandom_range(0, 1));
      wr_addr[j*AW +: AW] = AW'($urandom_range(0, amax));
      wr_data[j*XLEN +: XLEN] = $urandom;
    end
    for (int i = 0; i < NRD; i++)
      rd(i, AW'($urandom_range(0, amax)));
    sb_set_en   = 1'($urandom_range(0, 1));
    sb_set_addr = AW'($urandom_range(0, amax));
  endtask

  task automatic count_busy(input string nm);
    bl = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (busy) bl++;
      tick();
    end
    chk(nm, 32'(bl), 32'd31);
  endtask

  task automatic all_zero(input string nm);
    for (int r = 0; r < NREGS; r++) begin
      rd(0, AW'(r));
      rd(1, AW'(NREGS - 1 - r));
      @(negedge clk);
      chk(nm, rd_data[XLEN-1:0], 32'h0);
      chk(nm, 32'(rd_pending), 32'h0);
      tick();
    end
  endtask

  initial begin
    reset       = 1'b1;
    rd_addr     = '0;
    wr_addr     = '0;
    wr_data     = '0;
    sb_set_addr = '0;
    clr_in();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    count_busy("rst_busy_len");
    all_zero("post_reset_zero");

    wr(0, 5'd5, 32'hDEADBEEF);
    tick(); clr_in(); rd(0, 5'd5);
    @(negedge clk);
    chk("x5", rd_data[XLEN-1:0], 32'hDEADBEEF);
    tick();

    wr(0, 5'd0, 32'h1234);
    tick(); clr_in(); rd(0, 5'd0);
    @(negedge clk);
    chk("x0", rd_data[XLEN-1:0], 32'h0);
    tick();

    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    tick(); clr_in(); rd(0, 5'd7);
    @(negedge clk);
    chk("x7_prio", rd_data[XLEN-1:0], 32'h22);
    tick();

    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    tick(); clr_in(); rd(0, 5'd9); rd(1, 5'd9);
    @(negedge clk);
    chk("x9_pend_set", 32'(rd_pending), 32'h3);
    tick();
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    wr(0, 5'd9, 32'h55);
    tick(); clr_in();
    @(negedge clk);
    chk("x9_set_wins", 32'(rd_pending[0]), 32'h1);
    chk("x9_data", rd_data[XLEN-1:0], 32'h55);
    tick();
    wr(0, 5'd9, 32'h66);
    tick(); clr_in();
    @(negedge clk);
    chk("x9_pend_clr", 32'(rd_pending[0]), 32'h0);
    chk("x9_data2", rd_data[XLEN-1:0], 32'h66);
    tick();

    wr(0, 5'd3, 32'h0BAD);
    tick(); clr_in();
    wr(0, 5'd3, 32'hA5A5A5A5); rd(0, 5'd3);
    @(negedge clk);
`ifdef REGFILE_WR_BYPASS_EN
    chk("x3_same_cycle", rd_data[XLEN-1:0], 32'hA5A5A5A5);
`else
    chk("x3_same_cycle", rd_data[XLEN-1:0], 32'h0BAD);
`endif
    tick(); clr_in();
    @(negedge clk);
    chk("x3_after", rd_data[XLEN-1:0], 32'hA5A5A5A5);
    tick();

    for (int r = 1; r < NREGS; r++) begin
      wr(0, AW'(r), $urandom | 32'h1);
      tick();
    end
    clr_in();
    rd(0, 5'd31);
    @(negedge clk);
    chk("x31_filled", 32'(rd_data[XLEN-1:0] != 0), 32'h1);
    tick();

    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    bl = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (busy) bl++;
      tick();
      clr_in();
      if (i < 24) begin
        rnd_in(NREGS - 1);
        clear_req = (i == 5);
      end
    end
    clr_in();
    chk("clr_busy_len", 32'(bl), 32'd31);
    all_zero("post_clear_zero");

    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy("rst_mid_busy_len");

    for (int n = 0; n < 3000; n++) begin
      clr_in();
      rnd_in(($urandom_range(0, 1) == 1) ? 7 : NREGS - 1);
      clear_req = ($urandom_range(0, 149) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      tick();
    end
    clr_in();
    reset = 1'b0;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, the next generation of the processor's register file. Provides NRD combinational read ports, NWR write ports, and a pending-write scoreboard for pipelined issue. A hardware clear sequencer zeroes the array after reset or on request. Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, register count (power of two, >=4); AW = $clog2(NREGS)
NRD, 2, number of read ports (>=1)
NWR, 1, number of write ports (1..4)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high
rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  output  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_pending  output  NRD  port i's register has an outstanding write
wr_en  input  NWR  write enables
wr_addr  input  NWR*AW  write addresses
wr_data  input  NWR*XLEN  write data
sb_set_en  input  1  mark sb_set_addr pending (instruction issued)
sb_set_addr  input  AW  destination register being issued
clear_req  input  1  one-cycle pulse, request full clear
busy  output  1  clear sequence active; all writes/sets ignored

Behaviour:
- Reads combinational. Address 0 always returns 0 and rd_pending=0.
- Writes on posedge clk when wr_en[j]=1, state IDLE, and wr_addr[j]!=0. Writes to address 0 are discarded.
- Same address written by several ports in one cycle: the highest-index port wins.
- Storage array has no reset term. Only state, ptr and pending are async-reset.
- Clear FSM, states IDLE and CLEAR, 1-bit state plus AW-bit ptr:
  - reset asserted: state=CLEAR, ptr=1, pending=all 0, busy=1.
  - CLEAR: zero registers[ptr] each cycle, then ptr++. When ptr==NREGS-1 is written, go to IDLE next edge. Sequence takes NREGS-1 cycles after reset deasserts (31 at default).
  - IDLE plus clear_req: go to CLEAR, ptr=1, pending=all 0 at that edge. Writes and sets in the same cycle are still performed and are then overwritten by the clear.
  - clear_req during CLEAR: ignored, no restart.
  - reset mid-CLEAR: restarts at ptr=1.
- busy = (state==CLEAR). While busy: rd_data=0, rd_pending=0, wr_en and sb_set_en ignored.
- Scoreboard pending[NREGS-1:1]:
  - sb_set_en with sb_set_addr!=0 sets the bit.
  - any wr_en[j] clears the bit for wr_addr[j].
  - set and clear of the same address in one cycle: set wins.
  - rd_pending[i] = pending[rd_addr[i]], combinational.
- Reset values of outputs: busy=1, rd_data=0, rd_pending=0.

Optional Feature:
Macro REGFILE_WR_BYPASS_EN.
- Defined: when IDLE, a read whose address matches an active write (wr_en[j], addr!=0) returns that cycle's wr_data (highest matching j). rd_pending for that port reads 0 unless sb_set_en sets the same address in that cycle.
- Undefined: reads return pre-edge array contents and pre-edge pending.

Test Plan:
- Reset 3 cycles, release -> busy=1 for exactly 31 cycles then 0; all 31 registers read 0; rd_pending all 0.
- IDLE, write x5=0xDEADBEEF, next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF. Write x0=0x1234 -> x0 reads 0.
- NWR=2: both ports write x7 in one cycle (0x11, 0x22) -> x7=0x22.
- sb_set x9 -> rd_pending=1 on a port reading 9. Then a cycle with sb_set x9 plus write x9=0x55 -> pending stays 1. Then write-only x9 -> pending 0.
- With REGFILE_WR_BYPASS_EN: write x3=0xA5A5A5A5 while reading x3 in the same cycle -> rd_data=0xA5A5A5A5. Without the macro -> the old value.
- clear_req after filling x1..x31 -> busy 31 cycles, writes during busy dropped, all read 0 afterward. Assert reset at ptr=10 -> busy restarts for 31 cycles.
